// File: rtl/display_scan_driver_if.sv
// Display bus between the stopwatch timer logic and the scan driver.
// The master supplies the binary count and the blanking mode. The slave
// returns the multiplexed digit, the one-hot select, the blank flag and
// the overflow flag.
interface display_scan_driver_if #(
   parameter int BIN_W = 14
);
   logic [BIN_W-1:0] value;
   logic             blank_lz;
   logic [3:0]       digit;
   logic [3:0]       position;
   logic             blank;
   logic             overflow;

   modport master (
      output value,
      output blank_lz,
      input  digit,
      input  position,
      input  blank,
      input  overflow
   );

   modport slave (
      input  value,
      input  blank_lz,
      output digit,
      output position,
      output blank,
      output overflow
   );
endinterface

// File: rtl/display_scan_driver.sv
// Stopwatch display stage. A sequential double-dabble engine converts the
// binary count to four BCD digits, and a free-running dwell timer scans
// those digits onto one shared digit bus with one-hot select lines.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | compare value with last converted value, start on mismatch
// SHIFT  | BIN_W add-3/shift steps on {bcd, bin}
// COMMIT | publish BCD (or saturated 9999) and overflow to the scan side
module display_scan_driver #(
   parameter int CLK_HZ     = 50000000,
   parameter int REFRESH_HZ = 1000,
   parameter int BIN_W      = 14
) (
   input logic                  CLOCK_50,
   input logic                  reset,
   display_scan_driver_if.slave bus
);

   localparam int DWELL = CLK_HZ / REFRESH_HZ;
   localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] SH_LAST  = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_COMMIT
   } state_t;

   state_t           state_q, state_d;
   logic             last_vld_q, last_vld_d;
   logic [BIN_W-1:0] last_value_q, last_value_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [15:0]      bcd_q, bcd_d;
   logic [CNT_W-1:0] sh_cnt_q, sh_cnt_d;
   logic [15:0]      disp_q, disp_d;
   logic             ovf_q, ovf_d;
   logic [DW_W-1:0]  dwell_q, dwell_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       position_q, position_d;
   logic [3:0]       digit_q, digit_d;
   logic             blank_q, blank_d;

   logic [15:0] bcd_adj;
   logic [31:0] cap_ext;
   logic [3:0]  nib_sel;
   logic        z1, z2, z3;
   logic        blank_sel;

   // Add-3 correction on every nibble that would reach 10 or more after the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < 4; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end
      end
   end

   // Digit selection and leading-zero blanking for the position being scanned.
   always_comb begin
      cap_ext = {{(32-BIN_W){1'b0}}, last_value_q};
      z3 = (disp_q[15:12] == 4'd0);
      z2 = z3 && (disp_q[11:8] == 4'd0);
      z1 = z2 && (disp_q[7:4] == 4'd0);
      case (idx_q)
         2'd0:    begin nib_sel = disp_q[3:0];   blank_sel = 1'b0;             end
         2'd1:    begin nib_sel = disp_q[7:4];   blank_sel = bus.blank_lz && z1; end
         2'd2:    begin nib_sel = disp_q[11:8];  blank_sel = bus.blank_lz && z2; end
         default: begin nib_sel = disp_q[15:12]; blank_sel = bus.blank_lz && z3; end
      endcase
   end

   // Next-state logic for the conversion FSM, the dwell timer and the scan outputs.
   always_comb begin
      state_d      = state_q;
      last_vld_d   = last_vld_q;
      last_value_d = last_value_q;
      bin_d        = bin_q;
      bcd_d        = bcd_q;
      sh_cnt_d     = sh_cnt_q;
      disp_d       = disp_q;
      ovf_d        = ovf_q;
      dwell_d      = dwell_q;
      idx_d        = idx_q;

      case (state_q)
         S_IDLE: begin
            if (!last_vld_q || (bus.value != last_value_q)) begin
               last_vld_d   = 1'b1;
               last_value_d = bus.value;
               bin_d        = bus.value;
               bcd_d        = '0;
               sh_cnt_d     = '0;
               state_d      = S_SHIFT;
            end
         end
         S_SHIFT: begin
            bcd_d    = {bcd_adj[14:0], bin_q[BIN_W-1]};
            bin_d    = {bin_q[BIN_W-2:0], 1'b0};
            sh_cnt_d = sh_cnt_q + CNT_W'(1);
            if (sh_cnt_q == SH_LAST) begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            // Anything past four digits saturates; the BCD accumulator is not trusted there.
            if (cap_ext > 32'd9999) begin
               disp_d = 16'h9999;
               ovf_d  = 1'b1;
            end else begin
               disp_d = bcd_q;
               ovf_d  = 1'b0;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (dwell_q == DW_LAST) begin
         dwell_d = '0;
         idx_d   = idx_q + 2'd1;
      end else begin
         dwell_d = dwell_q + DW_W'(1);
      end

      // Outputs follow idx_q, so position, digit and blank always move together.
      position_d = 4'b0001 << idx_q;
      digit_d    = blank_sel ? 4'hF : nib_sel;
      blank_d    = blank_sel;
   end

   // State register with synchronous reset; clearing last_vld forces a reconversion.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_vld_q   <= 1'b0;
         last_value_q <= '0;
         bin_q        <= '0;
         bcd_q        <= '0;
         sh_cnt_q     <= '0;
         disp_q       <= '0;
         ovf_q        <= 1'b0;
         dwell_q      <= '0;
         idx_q        <= '0;
         position_q   <= 4'b0001;
         digit_q      <= 4'd0;
         blank_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_vld_q   <= last_vld_d;
         last_value_q <= last_value_d;
         bin_q        <= bin_d;
         bcd_q        <= bcd_d;
         sh_cnt_q     <= sh_cnt_d;
         disp_q       <= disp_d;
         ovf_q        <= ovf_d;
         dwell_q      <= dwell_d;
         idx_q        <= idx_d;
         position_q   <= position_d;
         digit_q      <= digit_d;
         blank_q      <= blank_d;
      end
   end

   assign bus.digit    = digit_q;
   assign bus.position = position_q;
   assign bus.blank    = blank_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with DWELL = 4.
module tb_display_scan_driver;

   logic CLOCK_50;
   logic reset;

   display_scan_driver_if #(.BIN_W(14)) bus ();

   display_scan_driver #(
      .CLK_HZ    (16),
      .REFRESH_HZ(4),
      .BIN_W     (14)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .bus     (bus)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic [13:0]     value;
      logic            blank_lz;
      logic [3:0][3:0] dig;
      logic [3:0]      blk;
      logic            ovf;
   } vec_t;

   int   n_checks;
   int   n_fail;
   vec_t tbl [11];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic int pos_idx(input logic [3:0] p);
      int r;
      r = -1;
      for (int i = 0; i < 4; i++) if (p == (4'b0001 << i)) r = i;
      return r;
   endfunction

   task automatic step();
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic scan_check(input vec_t v, input string tag);
      int k;
      for (int s = 0; s < 16; s++) begin
         step();
         k = pos_idx(bus.position);
         check({tag, "_onehot"}, (k >= 0) ? 1 : 0, 1);
         if (k >= 0) begin
            check({tag, "_digit"}, int'(bus.digit), int'(v.dig[k]));
            check({tag, "_blank"}, int'(bus.blank), int'(v.blk[k]));
         end
         check({tag, "_ovf"}, int'(bus.overflow), int'(v.ovf));
      end
   endtask

   initial begin
      logic [3:0][3:0] d1234;
      logic [3:0][3:0] d5678;
      logic [3:0][3:0] d42;
      vec_t            v;
      int              k;
      int              expd;
      logic [3:0]      prev_pos;
      int              run;
      bit              seen_change;

      n_checks = 0;
      n_fail   = 0;
      d1234 = 16'h1234;
      d5678 = 16'h5678;
      d42   = 16'hFF42;

      tbl[0]  = '{14'd1234,  1'b0, 16'h1234, 4'b0000, 1'b0};
      tbl[1]  = '{14'd7,     1'b1, 16'hFFF7, 4'b1110, 1'b0};
      tbl[2]  = '{14'd1007,  1'b1, 16'h1007, 4'b0000, 1'b0};
      tbl[3]  = '{14'd12000, 1'b0, 16'h9999, 4'b0000, 1'b1};
      tbl[4]  = '{14'd9999,  1'b0, 16'h9999, 4'b0000, 1'b0};
      tbl[5]  = '{14'd50,    1'b1, 16'hFF50, 4'b1100, 1'b0};
      tbl[6]  = '{14'd10000, 1'b1, 16'h9999, 4'b0000, 1'b1};
      tbl[7]  = '{14'd16383, 1'b0, 16'h9999, 4'b0000, 1'b1};
      tbl[8]  = '{14'd908,   1'b1, 16'hF908, 4'b1000, 1'b0};
      tbl[9]  = '{14'd0,     1'b1, 16'hFFF0, 4'b1110, 1'b0};
      tbl[10] = '{14'd0,     1'b0, 16'h0000, 4'b0000, 1'b0};

      // Reset state and post-reset scan order with first-conversion latency.
      reset        = 1'b1;
      bus.value    = 14'd1234;
      bus.blank_lz = 1'b0;
      wait_cycles(2);
      check("rst_position", int'(bus.position), 1);
      check("rst_digit",    int'(bus.digit),    0);
      check("rst_blank",    int'(bus.blank),    0);
      check("rst_overflow", int'(bus.overflow), 0);
      reset = 1'b0;
      for (int j = 0; j < 32; j++) begin
         step();
         k = (j / 4) % 4;
         check("post_rst_position", int'(bus.position), int'(4'b0001 << k));
         expd = (j < 16) ? 0 : int'(d1234[k]);
         check("post_rst_digit", int'(bus.digit), expd);
      end

      // Table of steady-state display patterns.
      for (int i = 0; i < 11; i++) begin
         bus.value    = tbl[i].value;
         bus.blank_lz = tbl[i].blank_lz;
         wait_cycles(40);
         scan_check(tbl[i], "vec");
      end

      // Value changes mid-conversion: 1234 commits whole, then 5678, never a mix.
      bus.value = 14'd1234;
      for (int t = 0; t <= 40; t++) begin
         step();
         k = pos_idx(bus.position);
         check("tear_onehot", (k >= 0) ? 1 : 0, 1);
         if (k >= 0) begin
            if (t <= 15)      expd = 0;
            else if (t <= 31) expd = int'(d1234[k]);
            else              expd = int'(d5678[k]);
            check("tear_digit", int'(bus.digit), expd);
         end
         if (t == 4) bus.value = 14'd5678;
      end

      // One-cycle reset in the middle of a conversion.
      bus.value = 14'd12000;
      wait_cycles(40);
      check("pre_rst_overflow", int'(bus.overflow), 1);
      bus.value = 14'd4321;
      wait_cycles(4);
      reset = 1'b1;
      step();
      check("mid_rst_position", int'(bus.position), 1);
      check("mid_rst_digit",    int'(bus.digit),    0);
      check("mid_rst_overflow", int'(bus.overflow), 0);
      reset = 1'b0;
      wait_cycles(16);
      v = '{14'd4321, 1'b0, 16'h4321, 4'b0000, 1'b0};
      scan_check(v, "reconv");

      // Long hold: stable digits, one-hot select and exact dwell length.
      bus.value    = 14'd42;
      bus.blank_lz = 1'b1;
      wait_cycles(40);
      prev_pos    = bus.position;
      run         = 0;
      seen_change = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         step();
         k = pos_idx(bus.position);
         check("hold_onehot", (k >= 0) ? 1 : 0, 1);
         if (k >= 0) check("hold_digit", int'(bus.digit), int'(d42[k]));
         if (bus.position != prev_pos) begin
            if (seen_change) check("hold_dwell_len", run, 4);
            seen_change = 1'b1;
            run = 1;
         end else begin
            run++;
         end
         prev_pos = bus.position;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
